// File: rtl/mult_seq_ctrl.sv
// Sequential shift-and-add multiplier: one partial product per clock, N cycles per operation.
// Define MULT_SEQ_EARLY_EXIT_EN to finish once no set multiplier bits remain.
module mult_seq_ctrl #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           ready,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [N-1:0]    a_lat, b_lat;
    logic [2*N-1:0]  acc;
    logic [CW-1:0]   cnt;
    logic [2*N-1:0]  pp;
    logic            last_add;

    // Partial product for multiplier bit cnt, aligned to its weight.
    always_comb begin
        pp = {{N{1'b0}}, a_lat & {N{b_lat[cnt]}}} << cnt;
    end

`ifdef MULT_SEQ_EARLY_EXIT_EN
    always_comb begin
        last_add = (cnt == CNT_LAST) ||
                   ((b_lat >> ((CW+1)'(cnt) + (CW+1)'(1))) == '0);
    end
`else
    always_comb begin
        last_add = (cnt == CNT_LAST);
    end
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block is given a default first, so no path infers a latch.
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) state_nxt = ACC;
            end
            ACC: begin
                busy = 1'b1;
                if (last_add) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: operand latches are reset too, keeping pp free of X after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_lat <= '0;
            b_lat <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_lat <= a;
                        b_lat <= b;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                ACC: begin
                    acc <= acc + pp;
                    cnt <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign product = acc;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed self-checking bench for mult_seq_ctrl (N=4), expectations hand-computed per vector.
module tb_mult_seq_ctrl;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [N-1:0]   a, b;
    logic           ready, busy, done;
    logic [2*N-1:0] product;

    int errors = 0;
    int checks = 0;
    int n;
    int seen;

    mult_seq_ctrl #(.N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

`ifdef MULT_SEQ_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock edge, then sample 1 time unit later; status flags must be one-hot every cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        check("onehot", 32'($onehot({ready, busy, done})), 32'd1);
    endtask

    task automatic start_op(input logic [N-1:0] x, input logic [N-1:0] y, input logic hold);
        a = x;
        b = y;
        start = 1'b1;
        tick();
        start = hold;
        check("accepted_busy", 32'(busy), 32'd1);
    endtask

    task automatic wait_done(output int cnt_edges);
        cnt_edges = 0;
        while (done !== 1'b1 && cnt_edges < 20) begin
            tick();
            cnt_edges++;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_product", 32'(product), 32'd0);

        // 15*15: full-width operands
        start_op(4'd15, 4'd15, 1'b0);
        wait_done(n);
        check("ff_latency", n, 32'd4);
        check("ff_product", 32'(product), 32'd225);
        tick();
        check("ff_done_one_cycle", 32'(done), 32'd0);
        check("ff_ready_after", 32'(ready), 32'd1);
        check("ff_product_held", 32'(product), 32'd225);
        tick();
        check("idle_hold_product", 32'(product), 32'd225);

        // 5*3 with operands cleared mid-operation
        start_op(4'd5, 4'd3, 1'b0);
        a = '0; b = '0;
        wait_done(n);
        check("chg_latency", n, EARLY ? 32'd2 : 32'd4);
        check("chg_product", 32'(product), 32'd15);
        tick();

        // start held during ACC and DONE with other operands: ignored
        start_op(4'd6, 4'd5, 1'b1);
        a = 4'd3; b = 4'd3;
        wait_done(n);
        check("ign_latency", n, EARLY ? 32'd3 : 32'd4);
        check("ign_product", 32'(product), 32'd30);
        tick();
        check("ign_ready_after_done", 32'(ready), 32'd1);
        start = 1'b0;
        tick();
        check("ign_no_restart", 32'(ready), 32'd1);
        check("ign_product_intact", 32'(product), 32'd30);

        // back-to-back with start held high
        start_op(4'd9, 4'd7, 1'b1);
        wait_done(n);
        check("b2b_latency", n, EARLY ? 32'd3 : 32'd4);
        check("b2b_product1", 32'(product), 32'd63);
        tick();
        n = 1;
        while (done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("b2b_period", n, EARLY ? 32'd5 : 32'd6);
        check("b2b_product2", 32'(product), 32'd63);
        start = 1'b0;
        tick();
        check("b2b_idle", 32'(ready), 32'd1);

        // reset mid-ACC at E2
        start_op(4'd7, 4'd3, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        check("mid_rst_ready", 32'(ready), 32'd1);
        check("mid_rst_product", 32'(product), 32'd0);
        // start together with rst is not accepted
        start = 1'b1; a = 4'd15; b = 4'd15;
        tick();
        check("rst_start_ready", 32'(ready), 32'd1);
        rst = 1'b0; start = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        check("mid_rst_no_done", seen, 32'd0);
        start_op(4'd2, 4'd2, 1'b0);
        wait_done(n);
        check("post_rst_latency", n, EARLY ? 32'd2 : 32'd4);
        check("post_rst_product", 32'(product), 32'd4);
        tick();

        // zero and unit multiplier
        start_op(4'd11, 4'd0, 1'b0);
        wait_done(n);
        check("b0_latency", n, EARLY ? 32'd1 : 32'd4);
        check("b0_product", 32'(product), 32'd0);
        tick();
        start_op(4'd11, 4'd1, 1'b0);
        wait_done(n);
        check("b1_latency", n, EARLY ? 32'd1 : 32'd4);
        check("b1_product", 32'(product), 32'd11);
        tick();
        check("b1_ready", 32'(ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_seq_ctrl.md
MULT_SEQ_CTRL -- requirements
Module: mult_seq_ctrl

Interface
- REQ-001: Parameter N, default 4: operand width in bits; the product is 2N bits wide; N SHALL be >= 2.
- REQ-002: clk, input, 1 bit: the single clock; all state SHALL update on the rising edge.
- REQ-003: rst, input, 1 bit: synchronous, active-high reset, sampled on the rising clk edge.
- REQ-004: start, input, 1 bit: request to multiply; it is accepted only while ready=1.
- REQ-005: a, input, N bits: unsigned multiplicand; it is latched when start is accepted.
- REQ-006: b, input, N bits: unsigned multiplier; it is latched when start is accepted.
- REQ-007: ready, output, 1 bit: high only in state IDLE.
- REQ-008: busy, output, 1 bit: high only in state ACC.
- REQ-009: done, output, 1 bit: high only in state DONE, for exactly one cycle per operation.
- REQ-010: product, output, 2N bits: the registered accumulator; it holds the final result from DONE until the next start is accepted.

Function
- REQ-011: The FSM SHALL have exactly three states: IDLE, ACC and DONE. Encoding is free, and unreachable codes SHALL return to IDLE.
- REQ-012: In IDLE with start=1 at an edge, the block SHALL:
  - latch a and b;
  - clear the accumulator and count (cnt) to 0;
  - enter ACC.
- REQ-013: In IDLE with start=0, the block SHALL hold its state. The product value SHALL remain unchanged.
- REQ-014: Each ACC edge SHALL add partial product k = (a_lat AND replicate(b_lat[k])) shifted left by k to the accumulator, where k = cnt.
  - The sum SHALL be computed modulo 2^(2N); it never overflows.
  - cnt SHALL increment after the add.
- REQ-015: When the add at cnt = N-1 completes, the FSM SHALL go from ACC to DONE. This gives exactly N accumulation edges.
- REQ-016: DONE SHALL last one cycle and then go to IDLE unconditionally.
- REQ-017: Latency: with start sampled at edge E0, done SHALL be high in the cycle after edge EN.
- REQ-018: start SHALL be ignored in ACC and DONE. It SHALL NOT restart, corrupt or extend the current operation.
- REQ-019: Changes on a or b after acceptance SHALL NOT affect the result.
- REQ-020: Back-to-back operation: start held high SHALL be accepted again in the first IDLE cycle after DONE, i.e. the edge following the DONE cycle.
- REQ-021: Exactly one of ready, busy and done SHALL be high in any cycle.

Reset
- REQ-022: With rst=1 at an edge, the block SHALL:
  - set the state to IDLE;
  - set ready=1, busy=0 and done=0;
  - set product=0 and cnt=0.
- REQ-023: rst SHALL take priority over start and over any in-flight operation. A reset mid-ACC SHALL discard the partial result, and no done SHALL follow.
- REQ-024: start SHALL NOT be accepted on an edge where rst=1.

Configuration
- REQ-025: Macro MULT_SEQ_EARLY_EXIT_EN, when defined, SHALL enable early termination:
  - after the add at cnt = k, if cnt = N-1 or b_lat >> (k+1) == 0, go to DONE;
  - b=0 therefore finishes after 1 accumulation edge.
- REQ-026: When MULT_SEQ_EARLY_EXIT_EN is undefined, every operation SHALL take exactly N accumulation edges.
- REQ-027: The product value SHALL be identical in both configurations.

Verification (N=4)
- REQ-028: a=15, b=15, start pulsed at E0 -> busy during E1..E4, done=1 in the cycle after E4, product=225 (0xE1); ready=1 on the following cycle.
- REQ-029: a=5, b=3, then a and b changed to 0 during ACC -> product=15. With the macro defined, done comes after E2; without it, done comes after E4.
- REQ-030: start held high continuously with a=9, b=7 -> product=63; done pulses every 6 cycles (1 IDLE + 4 ACC + 1 DONE); the macro is undefined.
- REQ-031: start asserted during ACC with different operands -> ignored; the first result is intact; no extra done.
- REQ-032: rst=1 at E2 of an operation -> cycle after: ready=1, product=0; no done. A new start (a=2, b=2) then gives product=4.
- REQ-033: Macro defined, a=11, b=0 -> done in the cycle after E1, product=0. With a=11, b=1 -> product=11 after E1.
